// File: rtl/delay_pkg.sv
// delay_pkg: shared width, FSM states and range limit for the delay line and its measurement stage
package delay_pkg;
    localparam int DELAY_W = 4;
    localparam logic [DELAY_W-1:0] DELAY_MAX = {DELAY_W{1'b1}};
    typedef enum logic [1:0] {IDLE, WAIT_REF, COUNT} state_t;
endpackage

// File: rtl/edge_rise.sv
// edge_rise: registered previous sample and combinational rising-edge detect
module edge_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);
    logic q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) q <= RST_VAL;
        else         q <= d_i;
    assign rise_o = d_i & ~q;
endmodule

// File: rtl/delay_meas.sv
// delay_meas: counts cycles from a reference rising edge to the matching edge on the delayed stream
module delay_meas
    import delay_pkg::*;
#(
    parameter int DELAY_W = delay_pkg::DELAY_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               ref_i,
    input  logic               dly_i,
    output logic               busy_o,
    output logic               valid_o,
    output logic [DELAY_W-1:0] delay_o,
    output logic               timeout_o
);
    state_t state, state_n;
    logic [DELAY_W-1:0] cnt, cnt_n, delay_n;
    logic timeout_n, valid_n, ref_rise, dly_rise;
    // samples reset high so a line already high after reset is not seen as an edge
    edge_rise #(.RST_VAL(1'b1)) u_ref (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(ref_i), .rise_o(ref_rise));
    edge_rise #(.RST_VAL(1'b1)) u_dly (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(dly_i), .rise_o(dly_rise));
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            delay_o   <= '0;
            timeout_o <= 1'b0;
            valid_o   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            delay_o   <= delay_n;
            timeout_o <= timeout_n;
            valid_o   <= valid_n;
        end
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        delay_n   = delay_o;
        timeout_n = timeout_o;
        valid_n   = 1'b0;
        case (state)
            IDLE: state_n = start_i ? WAIT_REF : IDLE;
            WAIT_REF:
                if (ref_rise && dly_rise) begin
                    delay_n   = '0;
                    timeout_n = 1'b0;
                    valid_n   = 1'b1;
                    state_n   = IDLE;
                end else if (ref_rise) begin
                    cnt_n   = DELAY_W'(1);
                    state_n = COUNT;
                end
            COUNT:
                // terminal compare exits before cnt could wrap
                if (dly_rise || cnt == {DELAY_W{1'b1}}) begin
                    delay_n   = dly_rise ? cnt : {DELAY_W{1'b1}};
                    timeout_n = ~dly_rise;
                    valid_n   = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            default: state_n = IDLE;
        endcase
    end
    assign busy_o = state != IDLE;
endmodule

// File: tb/tb_delay_meas.sv
// tb_delay_meas: directed and random delay measurements against a behavioural delay line
module tb_delay_meas;
    logic clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0, ref_i = 1'b0, dly_i;
    logic busy_o, valid_o, timeout_o;
    logic [3:0] delay_o;
    logic [15:0] hist = '0;
    logic [16:0] taps;
    logic man = 1'b0, dly_man = 1'b0, dly_en = 1'b1;
    int dly_d = 0;
    int n_cmp = 0, n_err = 0;

    delay_meas dut (.clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ref_i(ref_i), .dly_i(dly_i),
                    .busy_o(busy_o), .valid_o(valid_o), .delay_o(delay_o), .timeout_o(timeout_o));

    always #5 clk_i = ~clk_i;
    always_ff @(posedge clk_i) hist <= {hist[14:0], ref_i};
    assign taps  = {hist, ref_i};
    assign dly_i = man ? dly_man : (dly_en & taps[dly_d]);

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(input bit mid, output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        do begin
            step();
            n++;
            start_i = mid && n == 2;
            if (!valid_o) busy_ok &= busy_o;
        end while (!valid_o && n < 40);
        start_i = 1'b0;
    endtask

    task automatic arm(input int d, input bit live);
        man = 1'b0;
        dly_d = d;
        dly_en = live;
        ref_i = 1'b0;
        repeat (18) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("busy_armed", busy_o, 1);
        ref_i = 1'b1;
    endtask

    task automatic measure(input int d, input bit live, input bit mid);
        int n, ed;
        bit bok;
        ed = live ? d : 15;
        arm(d, live);
        wait_valid(mid, n, bok);
        check("latency", n, live ? d + 1 : 16);
        check("delay", delay_o, ed);
        check("timeout", timeout_o, live ? 0 : 1);
        check("busy_wait", bok, 1);
        check("busy_at_valid", busy_o, 0);
        step();
        check("valid_one_cycle", valid_o, 0);
        check("delay_held", delay_o, ed);
    endtask

    initial begin
        int n;
        bit bok, early;
        repeat (2) step();
        check("rst_busy", busy_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_delay", delay_o, 0);
        check("rst_timeout", timeout_o, 0);
        rst_ni = 1'b1;
        step();
        measure(5, 1, 0);
        measure(0, 1, 0);
        measure(15, 1, 0);
        measure(0, 0, 0);
        measure(9, 1, 1);
        measure(1, 1, 0);
        // ref already high at arm, falls, then rises; an earlier dly rise must be ignored
        man = 1'b1;
        dly_man = 1'b1;
        ref_i = 1'b1;
        repeat (3) step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        ref_i = 1'b0;
        dly_man = 1'b0;
        step();
        early = 1'b0;
        dly_man = 1'b1;
        step();
        early |= valid_o;
        dly_man = 1'b0;
        step();
        early |= valid_o;
        check("no_early_valid", early, 0);
        check("busy_wait_ref", busy_o, 1);
        ref_i = 1'b1;
        n = 0;
        do begin
            step();
            n++;
            if (n == 4) dly_man = 1'b1;
        end while (!valid_o && n < 40);
        check("late_ref_latency", n, 5);
        check("late_ref_delay", delay_o, 4);
        check("late_ref_timeout", timeout_o, 0);
        man = 1'b0;
        // back-to-back: new start accepted in the valid cycle
        arm(6, 1);
        wait_valid(1'b0, n, bok);
        check("b2b_first", delay_o, 6);
        start_i = 1'b1;
        ref_i = 1'b0;
        step();
        start_i = 1'b0;
        check("b2b_busy", busy_o, 1);
        ref_i = 1'b1;
        wait_valid(1'b0, n, bok);
        check("b2b_latency", n, 7);
        check("b2b_delay", delay_o, 6);
        for (int i = 0; i < 100; i++) measure($urandom_range(0, 15), 1, 0);
        // reset mid-count after a nonzero result
        measure(12, 1, 0);
        arm(0, 0);
        repeat (5) step();
        check("busy_before_rst", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_valid", valid_o, 0);
        check("arst_delay", delay_o, 0);
        check("arst_timeout", timeout_o, 0);
        early = 1'b0;
        repeat (3) begin
            step();
            early |= valid_o;
        end
        check("no_valid_in_rst", early, 0);
        rst_ni = 1'b1;
        measure(7, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/delay_meas.md
# delay_meas

Measurement stage placed directly downstream of the programmable delay line (`delay_15`). It watches the undelayed reference bit and the delay line's output, and counts the clock cycles between a rising edge on the reference and the matching rising edge on the delayed stream. It reports that count as a registered result with a one-cycle valid pulse, or flags a timeout when no edge arrives within range. Used for in-system self-check and calibration of the delay setting.

## Interface
- `DELAY_W`, 4: width of the delay value. The measurable range is 0 .. 2**DELAY_W-1 cycles.
- `clk_i` in 1: clock. Everything is synchronous to its rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: arm request. Sampled only in IDLE.
- `ref_i` in 1: undelayed data, the same signal that drives `delay_15.data_i`.
- `dly_i` in 1: delayed data, from `delay_15.data_o`.
- `busy_o` out 1: high while in WAIT_REF or COUNT.
- `valid_o` out 1: one-cycle pulse when a result or a timeout is written.
- `delay_o` out DELAY_W: measured delay. Held until the next result is written.
- `timeout_o` out 1: set together with `valid_o` when no delayed edge arrived in range. Held with `delay_o`.

## Operation
- Edge detect:
  - `ref_q` and `dly_q` hold the previous-edge samples of `ref_i` and `dly_i`. They update every cycle, in every state.
  - A rise is detected when the input is 1 and its `_q` is 0.
  - Both `_q` registers reset to 1, so an input that is already high after reset produces no false edge.
- FSM states: IDLE, WAIT_REF, COUNT. Reset state is IDLE.
- IDLE, `start_i`=1: go to WAIT_REF. Edges seen on the same clock edge are ignored.
- WAIT_REF:
  - Waits indefinitely for a ref rise. A dly rise without a ref rise is ignored.
  - On a ref rise alone: `cnt` <= 1, go to COUNT.
  - On a ref rise and a dly rise together: write result `delay_o`=0, `timeout_o`=0, `valid_o`=1, go to IDLE.
- COUNT (`cnt` is the elapsed cycles since the ref edge):
  - dly rise: `delay_o` <= `cnt`, `timeout_o` <= 0, `valid_o` <= 1, go to IDLE.
  - Otherwise, if `cnt` == 2**DELAY_W-1: `delay_o` <= all ones, `timeout_o` <= 1, `valid_o` <= 1, go to IDLE.
  - Otherwise: `cnt` <= `cnt`+1.
  - Further ref rises are ignored.
- `cnt` is DELAY_W bits wide and never wraps, because the terminal compare exits first.
- `start_i` while busy is ignored. There is no abort. Reset is the only way to cancel a measurement.

## Timing
- Reset values: `busy_o`=0, `valid_o`=0, `delay_o`=0, `timeout_o`=0, `cnt`=0, state IDLE.
- Reset asserted mid-COUNT: the block returns to IDLE immediately. No `valid_o` pulse. The previous result is cleared to 0.
- All outputs are registered. `busy_o` is decoded from the registered state.
- Latency:
  - If the ref rise is sampled at edge k and the dly rise at edge k+d, then `valid_o`=1 and `delay_o`=d in the cycle after edge k+d.
  - A timeout is reported in the cycle after edge k+2**DELAY_W-1.
- `valid_o` is high for exactly one cycle. `busy_o` is 0 in that same cycle.
- A new `start_i` is accepted in the `valid_o` cycle itself, giving back-to-back measurements with no dead cycle.

## Structure
- `delay_pkg` holds:
  - the default `DELAY_W` localparam, shared with `delay_15`;
  - the `state_t` enum {IDLE, WAIT_REF, COUNT};
  - the `DELAY_MAX` = 2**DELAY_W-1 constant.
- Sub-module `edge_rise`:
  - one flop plus an AND gate, with a `RST_VAL` parameter;
  - instantiated twice, once for ref and once for dly.
- The FSM, the counter and the result registers stay in `delay_meas`.

## Test plan
- `delay_15` with delay 5, start, then ref 0->1 -> `valid_o` pulses 6 cycles after the ref edge, `delay_o`=5, `timeout_o`=0, `busy_o`=1 throughout the wait.
- ref and dly rising on the same edge (delay 0) -> `delay_o`=0 one cycle later, COUNT never entered.
- Delay 15 -> `delay_o`=15, `timeout_o`=0. Then dly held low after the ref edge -> `timeout_o`=1 and `delay_o`=4'hF at edge k+15+1.
- ref already high at start, falls, then rises 3 cycles later -> only the later rise starts timing. A dly rise before the ref rise is ignored.
- `start_i` pulsed mid-COUNT -> no effect. `start_i` in the `valid_o` cycle -> a second measurement starts, and 100 random delays 0..15 all match.
- `rst_ni` pulsed low during COUNT -> all outputs 0 asynchronously, no `valid_o`, and the block accepts a new start afterwards.
